// File: rtl/pwm_gen_pkg.sv
// pwm_gen_pkg: shared types, constants and helpers for the PWM generator.
//   pwm_state_e  - channel-group arming state (DISARMED / ARMED / FAILSAFE)
//   HZ_PER_MHZ   - CLK cycles per us = CLK_HZ / HZ_PER_MHZ
//   US_PER_MS    - us ticks per ms tick
//   clamp_us()   - saturate a commanded width into [lo, hi]
//   is_clamped() - true when clamp_us() would change the value
package pwm_gen_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FAILSAFE = 2'd2
    } pwm_state_e;

    localparam int HZ_PER_MHZ = 1_000_000;
    localparam int US_PER_MS  = 1000;
    localparam int MS_CNT_W   = $clog2(US_PER_MS);

    function automatic logic [31:0] clamp_us(input logic [31:0] v,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    function automatic logic is_clamped(input logic [31:0] v,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (v < lo) || (v > hi);
    endfunction

endpackage

// File: rtl/pwm_tick_div.sv
// pwm_tick_div: us / ms tick prescaler.
//   CLK, RSTn  - clock, async active-low reset
//   en         - low holds both dividers at 0 and suppresses ticks
//   clr        - synchronous restart of the ms divider only (us phase kept,
//                so the PWM period is not disturbed by commands)
//   us_tick    - 1-cycle pulse every CYC_PER_US cycles
//   ms_tick    - 1-cycle pulse on every US_PER_MS-th us_tick
module pwm_tick_div
    import pwm_gen_pkg::*;
#(
    parameter int CYC_PER_US = 50
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic en,
    input  logic clr,
    output logic us_tick,
    output logic ms_tick
);

    localparam int PRE_W = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

    logic [PRE_W-1:0]    pre_cnt;
    logic [MS_CNT_W-1:0] ms_cnt;

    assign us_tick = en && (pre_cnt == PRE_W'(CYC_PER_US - 1));
    assign ms_tick = us_tick && !clr && (ms_cnt == MS_CNT_W'(US_PER_MS - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else if (!en) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
        end else begin
            pre_cnt <= us_tick ? '0 : pre_cnt + 1'b1;
            if (clr)
                ms_cnt <= '0;
            else if (us_tick)
                ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: N-channel servo/ESC PWM generator with double-buffered,
// clamped duty words, an arming gate and an optional command watchdog.
//   CLK, RSTn     - clock, async active-low reset
//   En            - block enable; low clears counters and forces outputs low
//   Arm           - level; high permits pulses (starting at the next wrap)
//   Duty_In       - channel k width in us at [k*DW +: DW]
//   Duty_Wr       - 1-cycle strobe capturing all of Duty_In into pending
//   Pwm_Out       - registered PWM outputs
//   Period_Start  - 1-cycle pulse in the first cycle of each period
//   Failsafe      - watchdog expired (always 0 without the watchdog)
//   Clamp_Flg     - per channel, last written value was clamped
// Build option: PWM_GEN_MULTI_WDT_EN builds the watchdog, Failsafe and the
// FAILSAFE state; otherwise the last commanded widths hold indefinitely.
module pwm_gen_multi
    import pwm_gen_pkg::*;
#(
    parameter int CH_NUM      = 8,
    parameter int DW          = 16,
    parameter int CLK_HZ      = 50_000_000,
    parameter int PERIOD_US   = 2500,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int FAILSAFE_US = 1000,
    parameter int WDT_MS      = 100
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 En,
    input  logic                 Arm,
    input  logic [CH_NUM*DW-1:0] Duty_In,
    input  logic                 Duty_Wr,
    output logic [CH_NUM-1:0]    Pwm_Out,
    output logic                 Period_Start,
    output logic                 Failsafe,
    output logic [CH_NUM-1:0]    Clamp_Flg
);

    localparam int            CYC_PER_US = CLK_HZ / HZ_PER_MHZ;
    localparam int            PW         = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam logic [DW-1:0] FS_W       = DW'(FAILSAFE_US);

    logic          us_tick, ms_tick, wrap;
    logic [PW-1:0] period_cnt, cnt_nx;
    pwm_state_e    state, state_nx;
    logic          sync_q, sync_nx;
    logic          fs_q, wdt_expire;

    pwm_tick_div #(.CYC_PER_US(CYC_PER_US)) u_div (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .en      (En),
        .clr     (Duty_Wr),
        .us_tick (us_tick),
        .ms_tick (ms_tick)
    );

    // ---------------- period counter ----------------
    assign wrap = us_tick && (period_cnt == PW'(PERIOD_US - 1));

    always_comb begin
        cnt_nx = period_cnt;
        if (!En || wrap)  cnt_nx = '0;
        else if (us_tick) cnt_nx = period_cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            period_cnt   <= '0;
            Period_Start <= 1'b0;
        end else begin
            period_cnt   <= cnt_nx;
            Period_Start <= wrap;
        end
    end

    // ---------------- watchdog ----------------
`ifdef PWM_GEN_MULTI_WDT_EN
    localparam int WW = $clog2(WDT_MS + 1);
    logic [WW-1:0] wdt_cnt;

    // A write in the expiry cycle wins: ms_tick is already masked by the
    // divider clear, the explicit term keeps the intent visible.
    assign wdt_expire = ms_tick && !Duty_Wr && (wdt_cnt == WW'(WDT_MS - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wdt_cnt <= '0;
            fs_q    <= 1'b0;
        end else begin
            if (!En || Duty_Wr)
                wdt_cnt <= '0;
            else if (ms_tick && wdt_cnt != WW'(WDT_MS))
                wdt_cnt <= wdt_cnt + 1'b1;
            if (Duty_Wr)         fs_q <= 1'b0;
            else if (wdt_expire) fs_q <= 1'b1;
        end
    end
`else
    localparam int unused_wdt_ms = WDT_MS;
    logic unused_ms;
    assign unused_ms  = ms_tick;
    assign wdt_expire = 1'b0;
    assign fs_q       = 1'b0;
`endif

    assign Failsafe = fs_q;

    // ---------------- arming state machine ----------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= DISARMED;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!Arm || !En) begin
            state_nx = DISARMED;
        end else begin
            case (state)
                DISARMED: state_nx = ARMED;
                ARMED:    if (fs_q && !Duty_Wr) state_nx = FAILSAFE;
                FAILSAFE: if (Duty_Wr)          state_nx = ARMED;
                default:  state_nx = DISARMED;
            endcase
        end
    end

    // Output gate: opens only at a wrap while armed so a partial first
    // pulse never appears, and closes in the same cycle as disarm.
    always_comb begin
        sync_nx = sync_q;
        if (state_nx == DISARMED) sync_nx = 1'b0;
        else if (wrap)            sync_nx = 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) sync_q <= 1'b0;
        else       sync_q <= sync_nx;
    end

    // ---------------- channels ----------------
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic [DW-1:0] din, pend_q, shad_q, shad_nx;
        logic          pwm_q, flg_q;

        assign din     = Duty_In[k*DW +: DW];
        // At a wrap the shadow takes the pending value from before this
        // edge, so a write coinciding with the wrap lands one period later.
        assign shad_nx = wrap ? pend_q : shad_q;

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                pend_q <= FS_W;
                shad_q <= FS_W;
                flg_q  <= 1'b0;
                pwm_q  <= 1'b0;
            end else begin
                if (Duty_Wr) begin
                    pend_q <= DW'(clamp_us(32'(din), 32'(MIN_US), 32'(MAX_US)));
                    flg_q  <= is_clamped(32'(din), 32'(MIN_US), 32'(MAX_US));
                end else if (wdt_expire) begin
                    pend_q <= FS_W;
                end
                shad_q <= shad_nx;
                // Compare next-cycle counter and shadow so the rising edge
                // lines up with Period_Start.
                pwm_q  <= sync_nx && (32'(cnt_nx) < 32'(shad_nx));
            end
        end

        assign Pwm_Out[k]   = pwm_q;
        assign Clamp_Flg[k] = flg_q;
    end

endmodule
